ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, 20000, clk_in cycles without a PS/2 clock falling edge after which a partial frame is abandoned.
- REQ-002: Parameter FILTER_LEN, 8, consecutive stable clk_in samples required by the glitch filter (REQ-024 only).
- REQ-003: clk_in  input  1  system clock; the single clock domain.
- REQ-004: rst_n_in  input  1  asynchronous, active-low reset.
- REQ-005: ps2_clk_in  input  1  raw PS/2 clock line, asynchronous to clk_in.
- REQ-006: ps2_data_in  input  1  raw PS/2 data line, asynchronous to clk_in.
- REQ-007: scancode_out  output  8  last correctly received byte, registered.
- REQ-008: valid_out  output  1  one-cycle pulse; scancode_out holds a new byte.
- REQ-009: error_out  output  1  one-cycle pulse; frame rejected (start/parity/stop/timeout).

Function
- REQ-010: ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer before any use.
- REQ-011: Falling edge SHALL be detected as previous synchronized clock = 1 and current = 0; data is sampled from the synchronized data line in that same cycle.
- REQ-012: Frame format SHALL be 11 bits: start (0), 8 data LSB first, odd parity, stop (1).
- REQ-013: States SHALL be IDLE, DATA, PARITY, STOP; 3-bit bit counter used in DATA.
- REQ-014: IDLE: edge with data 0 -> DATA, counter 0; edge with data 1 -> stay IDLE, pulse error_out.
- REQ-015: DATA: each edge shifts sampled bit into shift register MSB (right shift); after 8th bit -> PARITY.
- REQ-016: PARITY: edge captures parity bit -> STOP.
- REQ-017: STOP: edge -> IDLE; if stop bit = 1 and XOR(data, parity) = 1, load scancode_out and pulse valid_out the following cycle; otherwise pulse error_out the following cycle, scancode_out unchanged.
- REQ-018: Timeout counter SHALL clear on every falling edge and in IDLE; in any non-IDLE state reaching TIMEOUT_CYCLES-1 forces IDLE and pulses error_out next cycle.
- REQ-019: valid_out and error_out SHALL never assert in the same cycle; each is high for exactly one cycle per event.
- REQ-020: scancode_out SHALL change only in the cycle valid_out asserts.
- REQ-021: Output contract SHALL match downstream bridge: error_out resets its break-code tracking, valid_out qualifies scancode_out.

Reset
- REQ-022: rst_n_in low SHALL immediately force state IDLE, scancode_out 8'h00, valid_out 0, error_out 0, counters and shift register 0, synchronizer flops to 1 (idle line).
- REQ-023: Reset asserted mid-frame SHALL discard the partial frame with no valid_out or error_out pulse; reception resumes at the next start bit after release.

Configuration
- REQ-024: PS2_RX_GLITCH_FILTER_EN defined: the synchronized PS/2 clock SHALL pass a filter whose output changes only after FILTER_LEN consecutive equal samples (adds FILTER_LEN cycles edge latency); shorter pulses are ignored.
- REQ-025: PS2_RX_GLITCH_FILTER_EN undefined: the synchronized clock SHALL feed edge detection directly and FILTER_LEN is unused.

Verification
- REQ-026: Frame 0x1C, parity 0, stop 1, 12.5 kHz PS/2 clock -> single valid_out pulse, scancode_out = 0x1C, no error_out.
- REQ-027: Back-to-back frames 0xF0 (parity 1) then 0x1C -> two valid_out pulses with scancode_out 0xF0 then 0x1C.
- REQ-028: Frame 0x1C with parity 1 -> one error_out pulse, no valid_out, scancode_out keeps prior value; same with stop bit 0.
- REQ-029: Start + 4 data bits then clock held high -> error_out exactly TIMEOUT_CYCLES cycles after last edge (±2 sync); next frame 0x5A received correctly.
- REQ-030: Macro defined, 3-cycle low glitch on ps2_clk_in mid-frame -> ignored, frame 0x1C still valid; macro undefined -> glitch counted, frame rejected with error_out.
- REQ-031: rst_n_in pulsed low after 5 data bits -> outputs zero immediately, no pulses; following frame 0x1C yields valid_out.

Source files
------------

// File: rtl/ps2_rx_if.sv
// PS/2 receiver bus: raw PS/2 lines in, decoded scancode with valid/error pulses out.
interface ps2_rx_if;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic [7:0] scancode_out;
    logic       valid_out;
    logic       error_out;

    modport slave  (input  ps2_clk_in, ps2_data_in,
                    output scancode_out, valid_out, error_out);
    modport master (output ps2_clk_in, ps2_data_in,
                    input  scancode_out, valid_out, error_out);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB first, odd parity, stop) with timeout.
// Optional PS/2 clock glitch filter enabled by defining PS2_RX_GLITCH_FILTER_EN.
module ps2_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic      clk_in,
    input  logic      rst_n_in,
    ps2_rx_if.slave   bus
);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_clk_sync, r_data_sync;
    logic              r_clk_prev;
    logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_parity, w_parity_nxt;
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
    logic [DATA_W-1:0] r_scancode, w_scancode_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_error, w_error_nxt;
    logic              w_clk_filt;
    logic              w_fall;
    logic              w_data;

    // Two-flop synchronizers; reset to the idle-high line level.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], bus.ps2_clk_in};
            r_data_sync <= {r_data_sync[0], bus.ps2_data_in};
        end
    end

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    logic [FLT_W-1:0] r_filt_cnt;
    logic             r_filt_clk;

    // Output follows the synchronized clock only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_filt_cnt <= '0;
            r_filt_clk <= 1'b1;
        end else if (r_clk_sync[1] == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FLT_W'(FILTER_LEN - 1)) begin
            r_filt_cnt <= '0;
            r_filt_clk <= r_clk_sync[1];
        end else begin
            r_filt_cnt <= r_filt_cnt + FLT_W'(1);
        end
    end

    assign w_clk_filt = r_filt_clk;
`else
    assign w_clk_filt = r_clk_sync[1];
    // FILTER_LEN only shapes the glitch filter, which is absent in this build.
    if (FILTER_LEN == 0) begin : g_filter_len_unused
    end
`endif

    assign w_fall = r_clk_prev & ~w_clk_filt;
    assign w_data = r_data_sync[1];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_clk_prev <= 1'b1;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_to_cnt   <= '0;
            r_scancode <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_prev <= w_clk_filt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_scancode <= w_scancode_nxt;
            r_valid    <= w_valid_nxt;
            r_error    <= w_error_nxt;
        end
    end

    // Frame FSM: advances on each synchronized PS/2 clock falling edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_scancode_nxt = r_scancode;
        w_valid_nxt    = 1'b0;
        w_error_nxt    = 1'b0;
        w_to_cnt_nxt   = r_to_cnt + TO_W'(1);

        if (w_fall || r_state == S_IDLE) begin
            w_to_cnt_nxt = '0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    if (!w_data) begin
                        w_state_nxt   = S_DATA;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_nxt   = {w_data, r_shift[DATA_W-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_parity_nxt = w_data;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    if (w_data && ((^r_shift) ^ r_parity)) begin
                        w_valid_nxt    = 1'b1;
                        w_scancode_nxt = r_shift;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Stalled partial frame: abandon it.
        if (!w_fall && r_state != S_IDLE && r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt    = S_IDLE;
            w_error_nxt    = 1'b1;
            w_valid_nxt    = 1'b0;
            w_scancode_nxt = r_scancode;
        end
    end

    assign bus.scancode_out = r_scancode;
    assign bus.valid_out    = r_valid;
    assign bus.error_out    = r_error;
endmodule

// File: tb/tb_ps2_rx.sv
// Directed self-checking bench for ps2_rx: 12.5 kHz PS/2 frames against a 1 MHz system clock.
`timescale 1ns/1ps
module tb_ps2_rx;
    localparam int unsigned TO    = 4000;
    localparam int unsigned FL    = 8;
    localparam int unsigned HALF  = 40;
    localparam int unsigned CLK_P = 1000;
`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int unsigned LAT = FL + 1;
`else
    localparam int unsigned LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #(CLK_P / 2) clk = ~clk;

    ps2_rx_if bus ();

    ps2_rx #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int bad_change = 0;
    logic [7:0] prev_code = 8'h00;

    // Pulse counting and output-contract watch.
    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) valid_cnt <= valid_cnt + 1;
        if (bus.error_out === 1'b1) err_cnt <= err_cnt + 1;
        if (bus.valid_out === 1'b1 && bus.error_out === 1'b1) both_cnt <= both_cnt + 1;
        if (rst_n === 1'b1 && bus.valid_out !== 1'b1 && bus.scancode_out !== prev_code)
            bad_change <= bad_change + 1;
        prev_code <= bus.scancode_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clock_bit(input logic b, input bit glitch);
        bus.ps2_data_in = b;
        if (glitch) begin
            repeat (10) @(negedge clk);
            bus.ps2_clk_in = 1'b0;
            repeat (3) @(negedge clk);
            bus.ps2_clk_in = 1'b1;
            repeat (HALF - 13) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        bus.ps2_clk_in = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int glitch_at);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) clock_bit(bits[i], i == glitch_at);
        bus.ps2_data_in = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] d, input logic par,
                               input logic stp, input int glitch_at, input int exp_valid,
                               input int exp_err, input logic [7:0] exp_code);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(d, par, stp, glitch_at);
        repeat (5) @(negedge clk);
        check({tag, "_valid"}, valid_cnt - v0, exp_valid);
        check({tag, "_error"}, err_cnt - e0, exp_err);
        check({tag, "_code"}, bus.scancode_out, exp_code);
    endtask

    initial begin
        int v0, e0, n;
        bit hit;
        bus.ps2_clk_in  = 1'b1;
        bus.ps2_data_in = 1'b1;
        rst_n = 1'b1;
        #10 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_code", bus.scancode_out, 8'h00);
        check("rst_valid", bus.valid_out, 1'b0);
        check("rst_error", bus.error_out, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        frame_check("f1c", 8'h1C, 1'b0, 1'b1, -1, 1, 0, 8'h1C);
        frame_check("b2b_f0", 8'hF0, 1'b1, 1'b1, -1, 1, 0, 8'hF0);
        frame_check("b2b_1c", 8'h1C, 1'b0, 1'b1, -1, 1, 0, 8'h1C);
        frame_check("fa5", 8'hA5, 1'b1, 1'b1, -1, 1, 0, 8'hA5);
        frame_check("bad_par", 8'h1C, 1'b1, 1'b1, -1, 0, 1, 8'hA5);
        frame_check("bad_stop", 8'h1C, 1'b0, 1'b0, -1, 0, 1, 8'hA5);

        // Lone clock pulse with data high: a start bit of 1.
        v0 = valid_cnt;
        e0 = err_cnt;
        clock_bit(1'b1, 1'b0);
        repeat (HALF) @(negedge clk);
        check("start1_error", err_cnt - e0, 1);
        check("start1_valid", valid_cnt - v0, 0);

        // Start + 4 data bits, then the clock stays high.
        v0 = valid_cnt;
        e0 = err_cnt;
        clock_bit(1'b0, 1'b0);
        clock_bit(1'b0, 1'b0);
        clock_bit(1'b0, 1'b0);
        clock_bit(1'b1, 1'b0);
        bus.ps2_data_in = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk_in = 1'b0;
        n = 0;
        hit = 1'b0;
        while (!hit && n < int'(TO + 200)) begin
            @(negedge clk);
            n++;
            if (n == int'(HALF)) bus.ps2_clk_in = 1'b1;
            if (bus.error_out === 1'b1) hit = 1'b1;
        end
        check("to_seen", 32'(hit), 1);
        check("to_delay_ok", 32'(n >= int'(TO) && n <= int'(TO + 3 + LAT)), 1);
        repeat (20) @(negedge clk);
        check("to_error", err_cnt - e0, 1);
        check("to_valid", valid_cnt - v0, 0);
        frame_check("after_to", 8'h5A, 1'b1, 1'b1, -1, 1, 0, 8'h5A);

`ifdef PS2_RX_GLITCH_FILTER_EN
        frame_check("glitch", 8'h1C, 1'b0, 1'b1, 4, 1, 0, 8'h1C);
`else
        frame_check("glitch", 8'h1C, 1'b0, 1'b1, 4, 0, 2, 8'h5A);
`endif

        // Reset in the middle of a frame (start + 5 data bits of 0x1C).
        v0 = valid_cnt;
        e0 = err_cnt;
        clock_bit(1'b0, 1'b0);
        clock_bit(1'b0, 1'b0);
        clock_bit(1'b0, 1'b0);
        clock_bit(1'b1, 1'b0);
        clock_bit(1'b1, 1'b0);
        clock_bit(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        #100 rst_n = 1'b0;
        #1;
        check("midrst_code", bus.scancode_out, 8'h00);
        check("midrst_valid", bus.valid_out, 1'b0);
        check("midrst_error", bus.error_out, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus.ps2_data_in = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_valid", valid_cnt - v0, 0);
        check("midrst_no_error", err_cnt - e0, 0);
        frame_check("post_rst", 8'h1C, 1'b0, 1'b1, -1, 1, 0, 8'h1C);

        check("valid_error_overlap", both_cnt, 0);
        check("code_change_without_valid", bad_change, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
